xmpl_cic_out: RTL

Output conditioning stage directly downstream of the CIC decimator in the example DSP core. On each CIC output strobe it takes the 32-bit CIC result and applies a programmable rounding right-shift for gain normalisation. It saturates the result to signed 16 bits and buffers it in a small FIFO with a valid/ready interface toward the next consumer. It also reports FIFO overflow and saturation events.

---
 rtl/xmpl_cic_out.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/xmpl_cic_out.sv
// CIC output conditioning: rounding right-shift, signed saturation and a small
// valid/ready FIFO toward the next consumer, with sticky overflow/saturation status.
module xmpl_cic_out #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic [31:0]                cic_c32_i,
  input  logic                       cic_vld_i,
  input  logic [4:0]                 shift_i,
  input  logic                       clr_sticky_i,
  output logic [OUT_W-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_lvl_o,
  output logic                       ovf_o,
  output logic                       sat_o,
  output logic [7:0]                 sat_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_W - 1));

  // Stage 1 signals
  logic              accept;
  logic [4:0]        shift_eff;
  logic signed [32:0] x_ext;
  logic signed [32:0] round_bias;
  logic signed [32:0] rounded;
  logic              s1_vld;
  logic signed [32:0] s1_r;

  // Stage 2 / FIFO signals
  logic              sat_hi;
  logic              sat_lo;
  logic              sat_evt;
  logic [OUT_W-1:0]  wr_data;
  logic [OUT_W-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     count;
  logic              full;
  logic              pop;
  logic              do_write;
  logic              drop;

  assign accept = cic_vld_i & en_i;

  // Rounding shift: clamp the shift to 16, add half an LSB of the result, then shift arithmetically.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    shift_eff  = (shift_i > 5'd16) ? 5'd16 : shift_i;
    x_ext      = {cic_c32_i[31], cic_c32_i};
    round_bias = '0;
    if (shift_eff != 5'd0) round_bias = 33'sd1 <<< (shift_eff - 5'd1);
    rounded    = (x_ext + round_bias) >>> shift_eff;
  end

  // Stage 1 register: rounded value and its valid flag.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i) begin
      s1_vld <= 1'b0;
      s1_r   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_r <= rounded;
    end
  end

  // Saturate the stage-1 result to OUT_W signed bits.
  always_comb begin
    sat_hi  = (s1_r > SAT_MAX);
    sat_lo  = (s1_r < SAT_MIN);
    sat_evt = s1_vld & (sat_hi | sat_lo);
    wr_data = s1_r[OUT_W-1:0];
    if (sat_hi)      wr_data = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) wr_data = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // Push/pop decisions; a full FIFO still accepts a write when the head is popped the same cycle.
  always_comb begin
    full     = (count == LW'(DEPTH));
    pop      = out_valid_o & out_ready_i;
    do_write = s1_vld & (~full | pop);
    drop     = s1_vld & full & ~pop;
  end

  // FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: storage is reset because the head is visible on out_data_o and must read 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_write, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky status; a new event in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_o     <= 1'b0;
      sat_o     <= 1'b0;
      sat_cnt_o <= '0;
    end else begin
      if (drop)              ovf_o <= 1'b1;
      else if (clr_sticky_i) ovf_o <= 1'b0;

      if (sat_evt)           sat_o <= 1'b1;
      else if (clr_sticky_i) sat_o <= 1'b0;

      if (clr_sticky_i)                         sat_cnt_o <= sat_evt ? 8'd1 : 8'd0;
      else if (sat_evt && sat_cnt_o != 8'd255)  sat_cnt_o <= sat_cnt_o + 8'd1;
    end
  end

  // Output view of the FIFO head.
  always_comb begin
    out_data_o  = mem[rd_ptr];
    out_valid_o = (count != '0);
    fifo_lvl_o  = count;
  end

endmodule
